// File: rtl/gmii_pkg.sv
// Shared GMII constants and the receive deframer state type.
package gmii_pkg;

    localparam logic [7:0]  GMII_PREAMBLE   = 8'h55;
    localparam logic [7:0]  GMII_SFD        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } gmii_rx_state_e;

endpackage

// File: rtl/gmii_crc32_d8.sv
// Byte-parallel Ethernet CRC32 next-state (reflected, LSB of the byte first).
module gmii_crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_work;

    // Unrolled eight single-bit LFSR steps, one per data bit starting at bit 0.
    always_comb begin
        crc_work = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_work = {1'b0, crc_work[31:1]}
                     ^ (((crc_work[0] ^ data[i]) == 1'b1) ? CRC32_POLY_REFL : 32'h0);
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks the CRC, and
// streams DA..last payload byte with sop/eop/err markers plus frame counters.
module gmii_rx_deframer
    import gmii_pkg::*;
#(
    parameter int MIN_PREAMBLE = 1,
    parameter int MAX_FRAME    = 1518,
    parameter int MIN_FRAME    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  rxd,
    input  logic        rx_er,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_err,
    output logic [31:0] stat_frames_ok,
    output logic [31:0] stat_frames_err
);

    localparam logic [2:0]  MIN_PRE_CNT = 3'(MIN_PREAMBLE);
    localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME);
    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME);
    // Five bytes must be buffered before the oldest can be released, so the
    // four FCS bytes are still held back when rx_dv falls.
    localparam logic [15:0] EMIT_LEN    = 16'd5;

    gmii_rx_state_e  state_q, state_d;
    logic [2:0]      pre_cnt_q, pre_cnt_d, pre_cnt_eff;
    logic [31:0]     crc_q, crc_d, crc_next;
    logic [15:0]     len_q, len_d;
    logic            err_flag_q, err_flag_d;
    logic            sop_pend_q, sop_pend_d;
    logic            armed_q, armed_d;
    logic [4:0][7:0] dly_q, dly_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_sop_q, out_sop_d;
    logic            out_eop_q, out_eop_d;
    logic            out_err_q, out_err_d;
    logic [31:0]     ok_cnt_q, ok_cnt_d;
    logic [31:0]     err_cnt_q, err_cnt_d;

    logic pre_active;
    logic sfd_hit;
    logic pre_abort;
    logic data_byte;
    logic frame_end;
    logic giant;
    logic emit;
    logic frame_bad;
    logic count_ok;
    logic count_err;

    gmii_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (rxd),
        .crc_out (crc_next)
    );

    // Preamble rules also apply to the first byte seen in IDLE, with a zero
    // count, so no cycle is lost on entry. armed_q blocks that entry until
    // rx_dv has been seen low once after reset (no mid-frame pickup).
    assign pre_active  = rx_dv && ((state_q == PREAMBLE) || ((state_q == IDLE) && armed_q));
    assign pre_cnt_eff = (state_q == IDLE) ? 3'd0 : pre_cnt_q;
    assign sfd_hit     = pre_active && !rx_er && (rxd == GMII_SFD) && (pre_cnt_eff >= MIN_PRE_CNT);
    assign pre_abort   = pre_active && (rx_er || ((rxd != GMII_PREAMBLE) && !sfd_hit));

    assign data_byte = (state_q == DATA) && rx_dv;
    assign frame_end = (state_q == DATA) && !rx_dv;
    assign giant     = data_byte && (len_q >= MAX_LEN);
    assign emit      = (data_byte || frame_end) && (len_q >= EMIT_LEN);
    assign frame_bad = (crc_q != CRC32_RESIDUE) || err_flag_q
                     || (len_q < MIN_LEN) || (len_q < EMIT_LEN);
    assign count_ok  = frame_end && !frame_bad;
    assign count_err = (frame_end && frame_bad) || giant || pre_abort;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    if (!armed_q || pre_abort) begin
                        state_d = DROP;
                    end else if (sfd_hit) begin
                        state_d = DATA;
                    end else begin
                        state_d = PREAMBLE;
                    end
                end
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (pre_abort) begin
                    state_d = DROP;
                end else if (sfd_hit) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (giant) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: datapath updates, output beat and counter increments.
    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        crc_d       = crc_q;
        len_d       = len_q;
        err_flag_d  = err_flag_q;
        sop_pend_d  = sop_pend_q;
        armed_d     = armed_q | ~rx_dv;
        dly_d       = dly_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        out_err_d   = 1'b0;
        ok_cnt_d    = ok_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (pre_active && (rxd == GMII_PREAMBLE)) begin
            pre_cnt_d = (pre_cnt_eff == 3'd7) ? 3'd7 : pre_cnt_eff + 3'd1;
        end

        if (sfd_hit) begin
            crc_d      = CRC32_INIT;
            len_d      = 16'd0;
            err_flag_d = 1'b0;
            sop_pend_d = 1'b1;
        end

        if (data_byte) begin
            crc_d = crc_next;
            dly_d = {dly_q[3:0], rxd};
            if (len_q != 16'hFFFF) begin
                len_d = len_q + 16'd1;
            end
            if (rx_er) begin
                err_flag_d = 1'b1;
            end
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = dly_q[4];
            out_sop_d   = sop_pend_q;
            sop_pend_d  = 1'b0;
        end

        if (frame_end || giant) begin
            out_eop_d = emit;
            out_err_d = emit && (giant || frame_bad);
        end

        if (count_ok && (ok_cnt_q != 32'hFFFF_FFFF)) begin
            ok_cnt_d = ok_cnt_q + 32'd1;
        end
        if (count_err && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    // Datapath, output and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_q   <= 3'd0;
            crc_q       <= CRC32_INIT;
            len_q       <= 16'd0;
            err_flag_q  <= 1'b0;
            sop_pend_q  <= 1'b0;
            armed_q     <= 1'b0;
            dly_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            ok_cnt_q    <= 32'd0;
            err_cnt_q   <= 32'd0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            err_flag_q  <= err_flag_d;
            sop_pend_q  <= sop_pend_d;
            armed_q     <= armed_d;
            dly_q       <= dly_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_err_q   <= out_err_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_sop         = out_sop_q;
    assign out_eop         = out_eop_q;
    assign out_err         = out_err_q;
    assign stat_frames_ok  = ok_cnt_q;
    assign stat_frames_err = err_cnt_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed-plus-random bench for gmii_rx_deframer with a frame-level model.
module tb_gmii_rx_deframer;

    localparam int MIN_PREAMBLE = 1;
    localparam int MAX_FRAME    = 1518;
    localparam int MIN_FRAME    = 64;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rxd   = 8'h00;
    logic        rx_er = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic [31:0] stat_frames_ok;
    logic [31:0] stat_frames_err;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
        int         edgeNo;
    } beat_t;

    beat_t      obsQ[$];
    beat_t      expQ[$];
    beat_t      monBeat;
    logic [7:0] txQ[$];
    int         cyc        = 0;
    int         assertCnt  = 0;
    int         failCnt    = 0;
    int         expOk      = 0;
    int         expErr     = 0;
    int         lastDaEdge = 0;

    gmii_rx_deframer #(
        .MIN_PREAMBLE (MIN_PREAMBLE),
        .MAX_FRAME    (MAX_FRAME),
        .MIN_FRAME    (MIN_FRAME)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_dv           (rx_dv),
        .rxd             (rxd),
        .rx_er           (rx_er),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_err         (out_err),
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_err (stat_frames_err)
    );

    // 125 MHz receive clock.
    always #4 clk = ~clk;

    // Rising-edge counter used to measure output latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            monBeat.data   = out_data;
            monBeat.sop    = out_sop;
            monBeat.eop    = out_eop;
            monBeat.err    = out_err;
            monBeat.edgeNo = cyc;
            obsQ.push_back(monBeat);
        end
    end

    // Hard stop in case the run wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [7:0] d, input logic er);
        @(negedge clk);
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
    endtask

    // Standard Ethernet FCS over txQ[0..n-1], byte-at-a-time formulation.
    function automatic logic [31:0] fcsOf(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, txQ[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Fills txQ with len bytes (DA..FCS): random payload then FCS low byte first.
    task automatic buildFrame(input int len, input bit corrupt);
        logic [31:0] fcs;
        int          pay;
        txQ.delete();
        pay = (len >= 4) ? len - 4 : len;
        for (int i = 0; i < pay; i++) txQ.push_back(8'($urandom));
        if (len >= 4) begin
            fcs = fcsOf(pay);
            if (corrupt) fcs = fcs ^ (32'h1 << $urandom_range(31, 0));
            for (int i = 0; i < 4; i++) txQ.push_back(fcs[8*i +: 8]);
        end
    endtask

    task automatic addBeats(input int n, input bit err);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data   = txQ[i];
            b.sop    = (i == 0);
            b.eop    = (i == n - 1);
            b.err    = (i == n - 1) ? err : 1'b0;
            b.edgeNo = 0;
            expQ.push_back(b);
        end
    endtask

    // Drives one frame and records what the deframer should do with it.
    task automatic sendFrame(input int preCnt, input int len, input bit corrupt,
                             input int erIdx, input bit badPre, input int ipg);
        bit bad;
        buildFrame(len, corrupt);
        for (int i = 0; i < preCnt; i++) begin
            applyStimulus(1'b1, (badPre && i == 2) ? 8'h57 : 8'h55, 1'b0);
        end
        applyStimulus(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b1, txQ[i], (i == erIdx));
            if (i == 0) lastDaEdge = cyc + 1;
        end
        for (int i = 0; i < ipg; i++) applyStimulus(1'b0, 8'h00, 1'b0);

        if (badPre || preCnt < MIN_PREAMBLE) begin
            expErr++;
        end else if (len > MAX_FRAME) begin
            addBeats(MAX_FRAME - 4, 1'b1);
            expErr++;
        end else if (len <= 4) begin
            expErr++;
        end else begin
            bad = corrupt || (erIdx >= 0 && erIdx < len) || (len < MIN_FRAME);
            addBeats(len - 4, bad);
            if (bad) expErr++;
            else expOk++;
        end
    endtask

    // Lets the pipeline drain, then compares beats and counters.
    task automatic checkFrames(input string tag);
        int diffs;
        int n;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        diffs = 0;
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            if (obsQ[i].data !== expQ[i].data || obsQ[i].sop !== expQ[i].sop ||
                obsQ[i].eop !== expQ[i].eop ||
                (expQ[i].eop && obsQ[i].err !== expQ[i].err)) begin
                diffs++;
            end
        end
        checkOutput({tag, " beat count"}, obsQ.size(), expQ.size());
        checkOutput({tag, " beat diffs"}, diffs, 0);
        checkOutput({tag, " stat_frames_ok"}, stat_frames_ok, expOk);
        checkOutput({tag, " stat_frames_err"}, stat_frames_err, expErr);
        obsQ.delete();
        expQ.delete();
    endtask

    initial begin
        int latency;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_sop", out_sop, 0);
        checkOutput("reset out_eop", out_eop, 0);
        checkOutput("reset out_err", out_err, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset stat_frames_ok", stat_frames_ok, 0);
        checkOutput("reset stat_frames_err", stat_frames_err, 0);
        #2 reset = 1'b1;
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("idle out_valid", out_valid, 0);

        // Good minimum-size frame with long preamble; also latency of DA[0].
        sendFrame(7, 64, 1'b0, -1, 1'b0, 2);
        latency = (obsQ.size() > 0) ? obsQ[0].edgeNo - lastDaEdge : -1;
        checkOutput("first beat latency", latency, 5);
        checkFrames("good frame");

        // FCS bit flip.
        sendFrame(7, 64, 1'b1, -1, 1'b0, 2);
        checkFrames("bad fcs");

        // rx_er on payload byte 20.
        sendFrame(7, 64, 1'b0, 20, 1'b0, 2);
        checkFrames("rx_er payload");

        // Corrupt preamble byte.
        sendFrame(7, 64, 1'b0, -1, 1'b1, 2);
        checkFrames("bad preamble");

        // Oversize frame is cut at MAX_FRAME.
        sendFrame(7, 1600, 1'b0, -1, 1'b0, 2);
        checkFrames("giant");

        // Exactly MAX_FRAME is still good.
        sendFrame(3, MAX_FRAME, 1'b0, -1, 1'b0, 2);
        checkFrames("max frame");

        // Back-to-back frames with a single idle cycle, shortest legal preamble.
        sendFrame(1, $urandom_range(300, 64), 1'b0, -1, 1'b0, 1);
        sendFrame(7, $urandom_range(300, 64), 1'b0, -1, 1'b0, 1);
        checkFrames("one-cycle ipg");

        // SFD with no preamble, runt, length-5 and short-but-valid-CRC frames.
        sendFrame(0, 64, 1'b0, -1, 1'b0, 2);
        checkFrames("missing preamble");
        sendFrame(7, 3, 1'b0, -1, 1'b0, 2);
        checkFrames("runt");
        sendFrame(7, 5, 1'b0, -1, 1'b0, 2);
        checkFrames("length five");
        sendFrame(7, 40, 1'b0, -1, 1'b0, 2);
        checkFrames("undersize");

        // Randomized frames.
        for (int k = 0; k < 6; k++) begin
            sendFrame($urandom_range(7, 1), $urandom_range(200, 64), bit'($urandom_range(1, 0)),
                      -1, 1'b0, $urandom_range(3, 1));
            checkFrames("random frame");
        end

        // Reset in the middle of a frame, released while rx_dv is still high.
        buildFrame(100, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h55, 1'b0);
        applyStimulus(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, txQ[i], 1'b0);
            if (i == 30) begin
                #2 reset = 1'b0;
                #1;
                checkOutput("mid-frame reset outputs", {out_valid, out_sop, out_eop, out_err, out_data}, 0);
                checkOutput("mid-frame reset stat_frames_ok", stat_frames_ok, 0);
                checkOutput("mid-frame reset stat_frames_err", stat_frames_err, 0);
                obsQ.delete();
                expQ.delete();
                expOk  = 0;
                expErr = 0;
            end
            if (i == 34) begin
                #2 reset = 1'b1;
            end
        end
        checkFrames("after reset release");
        sendFrame(7, $urandom_range(150, 64), 1'b0, -1, 1'b0, 2);
        checkFrames("post-reset good frame");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
